// File: rtl/axi_mem_arbiter_if.sv
// Line-size constants shared by the core's memory-side blocks.
// Also defines axi_inf, the reduced AXI bundle used between the caches and memory.
package multicore_pkg;
    localparam int WORDS_PER_LINE = 4;
endpackage

interface axi_inf #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
);
    logic [ADDR_SIZE-1:0] ar_addr;
    logic                 ar_valid;
    logic                 ar_ready;
    logic [DATA_SIZE-1:0] r_data;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_ready;
    logic [ADDR_SIZE-1:0] aw_addr;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [DATA_SIZE-1:0] w_data;
    logic                 w_valid;
    logic                 w_last;
    logic                 w_ready;
    logic                 b_valid;
    logic                 b_ready;

    modport master (
        output ar_addr, ar_valid, input ar_ready,
        input  r_data, r_valid, r_last, output r_ready,
        output aw_addr, aw_valid, input aw_ready,
        output w_data, w_valid, w_last, input w_ready,
        input  b_valid, output b_ready
    );

    modport slave (
        input  ar_addr, ar_valid, output ar_ready,
        output r_data, r_valid, r_last, input r_ready,
        input  aw_addr, aw_valid, output aw_ready,
        input  w_data, w_valid, w_last, output w_ready,
        output b_valid, input b_ready
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Shares one memory AXI port between the I-cache (s0) and D-cache (s1), holding each grant for a full burst.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise s1 has fixed priority.
module axi_mem_arbiter
    import multicore_pkg::*;
#(
    parameter int BEATS     = WORDS_PER_LINE,
    parameter int ADDR_SIZE = 32
) (
    input  logic       i_aclk,
    input  logic       i_reset,
    axi_inf.slave      s0,
    axi_inf.slave      s1,
    axi_inf.master     m,
    output logic [1:0] o_rd_owner,
    output logic [1:0] o_wr_owner,
    output logic       o_err
);
    localparam int               CNT_W    = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    rd_state_t            rd_state, rd_state_nx;
    wr_state_t            wr_state, wr_state_nx;
    logic                 rd_sel, rd_sel_nx;
    logic                 wr_sel, wr_sel_nx;
    logic                 rd_pick, wr_pick;
    logic [CNT_W-1:0]     rd_cnt, wr_cnt;
    logic                 ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                 rd_err_set, wr_err_set;
    logic                 rd_req, rd_rready;
    logic                 wr_req, wr_wvalid, wr_wlast, wr_bready;
    logic [ADDR_SIZE-1:0] rd_addr, wr_addr;

`ifdef AXI_ARB_RR_EN
    logic rd_last_win, wr_last_win;

    // Last-winner only moves on a contested grant, so a lone request never costs the other port its turn.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            rd_last_win <= 1'b1;
            wr_last_win <= 1'b1;
        end else begin
            if (rd_state == R_IDLE && s0.ar_valid && s1.ar_valid) rd_last_win <= rd_pick;
            if (wr_state == W_IDLE && s0.aw_valid && s1.aw_valid) wr_last_win <= wr_pick;
        end
    end

    assign rd_pick = (s0.ar_valid && s1.ar_valid) ? ~rd_last_win : s1.ar_valid;
    assign wr_pick = (s0.aw_valid && s1.aw_valid) ? ~wr_last_win : s1.aw_valid;
`else
    assign rd_pick = s1.ar_valid;
    assign wr_pick = s1.aw_valid;
`endif

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
            rd_sel   <= 1'b0;
            wr_sel   <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            o_err    <= 1'b0;
        end else begin
            rd_state <= rd_state_nx;
            wr_state <= wr_state_nx;
            rd_sel   <= rd_sel_nx;
            wr_sel   <= wr_sel_nx;
            if (ar_hs)
                rd_cnt <= '0;
            else if (r_hs && rd_cnt != CNT_MAX)
                rd_cnt <= rd_cnt + 1'b1;
            if (aw_hs)
                wr_cnt <= '0;
            else if (w_hs && wr_cnt != CNT_MAX)
                wr_cnt <= wr_cnt + 1'b1;
            if (rd_err_set || wr_err_set)
                o_err <= 1'b1;
        end
    end

    // A beat is wrong if last lands off the final count, or the final count passes without last.
    assign rd_err_set = r_hs && (m.r_last ? (rd_cnt != CNT_LAST) : (rd_cnt >= CNT_LAST));
    assign wr_err_set = w_hs && (wr_wlast ? (wr_cnt != CNT_LAST) : (wr_cnt >= CNT_LAST));

    assign o_rd_owner = (rd_state == R_IDLE) ? 2'b00 : (rd_sel ? 2'b10 : 2'b01);
    assign o_wr_owner = (wr_state == W_IDLE) ? 2'b00 : (wr_sel ? 2'b10 : 2'b01);

    always_comb begin
        rd_state_nx = rd_state;
        rd_sel_nx   = rd_sel;
        rd_addr     = rd_sel ? s1.ar_addr  : s0.ar_addr;
        rd_req      = rd_sel ? s1.ar_valid : s0.ar_valid;
        rd_rready   = rd_sel ? s1.r_ready  : s0.r_ready;
        m.ar_addr   = rd_addr;
        m.ar_valid  = 1'b0;
        m.r_ready   = 1'b0;
        s0.ar_ready = 1'b0;
        s1.ar_ready = 1'b0;
        s0.r_valid  = 1'b0;
        s1.r_valid  = 1'b0;
        s0.r_last   = 1'b0;
        s1.r_last   = 1'b0;
        s0.r_data   = m.r_data;
        s1.r_data   = m.r_data;
        ar_hs       = 1'b0;
        r_hs        = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (s0.ar_valid || s1.ar_valid) begin
                    rd_sel_nx   = rd_pick;
                    rd_state_nx = R_ADDR;
                end
            end
            R_ADDR: begin
                m.ar_valid = rd_req;
                if (rd_sel) s1.ar_ready = m.ar_ready;
                else        s0.ar_ready = m.ar_ready;
                ar_hs = rd_req && m.ar_ready;
                if (ar_hs) rd_state_nx = R_DATA;
            end
            R_DATA: begin
                m.r_ready = rd_rready;
                if (rd_sel) begin
                    s1.r_valid = m.r_valid;
                    s1.r_last  = m.r_last;
                end else begin
                    s0.r_valid = m.r_valid;
                    s0.r_last  = m.r_last;
                end
                r_hs = m.r_valid && rd_rready;
                if (r_hs && m.r_last) rd_state_nx = R_IDLE;
            end
            default: rd_state_nx = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nx = wr_state;
        wr_sel_nx   = wr_sel;
        wr_addr     = wr_sel ? s1.aw_addr  : s0.aw_addr;
        wr_req      = wr_sel ? s1.aw_valid : s0.aw_valid;
        wr_wvalid   = wr_sel ? s1.w_valid  : s0.w_valid;
        wr_wlast    = wr_sel ? s1.w_last   : s0.w_last;
        wr_bready   = wr_sel ? s1.b_ready  : s0.b_ready;
        m.aw_addr   = wr_addr;
        m.aw_valid  = 1'b0;
        m.w_data    = wr_sel ? s1.w_data : s0.w_data;
        m.w_last    = wr_wlast;
        m.w_valid   = 1'b0;
        m.b_ready   = 1'b0;
        s0.aw_ready = 1'b0;
        s1.aw_ready = 1'b0;
        s0.w_ready  = 1'b0;
        s1.w_ready  = 1'b0;
        s0.b_valid  = 1'b0;
        s1.b_valid  = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_hs        = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (s0.aw_valid || s1.aw_valid) begin
                    wr_sel_nx   = wr_pick;
                    wr_state_nx = W_ADDR;
                end
            end
            W_ADDR: begin
                m.aw_valid = wr_req;
                if (wr_sel) s1.aw_ready = m.aw_ready;
                else        s0.aw_ready = m.aw_ready;
                aw_hs = wr_req && m.aw_ready;
                if (aw_hs) wr_state_nx = W_DATA;
            end
            W_DATA: begin
                m.w_valid = wr_wvalid;
                if (wr_sel) s1.w_ready = m.w_ready;
                else        s0.w_ready = m.w_ready;
                w_hs = wr_wvalid && m.w_ready;
                if (w_hs && wr_wlast) wr_state_nx = W_RESP;
            end
            W_RESP: begin
                m.b_ready = wr_bready;
                if (wr_sel) s1.b_valid = m.b_valid;
                else        s0.b_valid = m.b_valid;
                b_hs = m.b_valid && wr_bready;
                if (b_hs) wr_state_nx = W_IDLE;
            end
            default: wr_state_nx = W_IDLE;
        endcase
    end
endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Two-requester AXI arbiter that shares the single external memory AXI port between the instruction cache (port 0) and the data cache (port 1) of one core. Read and write channels are arbitrated independently. Each grant is held for a whole cache-line burst, and for writes through the response, so line fills and write-backs are never interleaved. Sits between the cache `axi` ports and the core's memory-side `axi_inf`.

## Interface

Parameters:
- `BEATS`, default `WORDS_PER_LINE`: beats per burst, from `multicore_pkg`.
- `ADDR_SIZE`, default 32: AXI address width.

Ports:
- `i_aclk`, in, 1: system clock. The block has one clock.
- `i_reset`, in, 1: reset, synchronous and active-high.
- `s0`, slave modport, `axi_inf`: instruction-cache side.
- `s1`, slave modport, `axi_inf`: data-cache side.
- `m`, master modport, `axi_inf`: memory side.
- `o_rd_owner`, out, 2: one-hot read grant. `00` means idle.
- `o_wr_owner`, out, 2: one-hot write grant. `00` means idle.
- `o_err`, out, 1: sticky error flag. Set when `m.r.last` or `s*.w.last` does not coincide with beat `BEATS-1`.

## Operation

Read FSM states are `R_IDLE`, `R_ADDR` and `R_DATA`.
- **`R_IDLE`:** sample `s0.ar.valid` and `s1.ar.valid`. If either is set, register the grant and go to `R_ADDR`.
- **`R_ADDR`:** route the granted port's `ar.addr` and `ar.valid` to `m`, and return `m.arready` to the granted port only. On the `ar` handshake, clear the beat counter and go to `R_DATA`.
- **`R_DATA`:** route `m.r.data`, `r.valid` and `r.last` to the granted port, and `rready` from it. Each `r` handshake increments the beat counter. The handshake with `r.last` returns to `R_IDLE`.

Write FSM states are `W_IDLE`, `W_ADDR`, `W_DATA` and `W_RESP`. It works the same way on `aw.valid`:
- **`W_ADDR`:** forward the `aw` channel.
- **`W_DATA`:** forward `w.data`, `w.valid` and `w.last`, and return `wready` to the granted port. Leave `W_DATA` after the handshake with `w.last`.
- **`W_RESP`:** forward `b.valid` and `bready`. Return to `W_IDLE` after the `b` handshake.

Common rules:
- The non-granted port sees `arready`, `awready`, `wready`, `r.valid` and `b.valid` all at 0. Its `r.data` is don't-care.
- The `m` valid outputs are 0 in the idle states.
- Arbitration uses the policy selected under Configuration.
- A simultaneous read grant to one port and write grant to the other is legal. The two FSMs share no state.
- Beat counter width is `$clog2(BEATS)+1`. It saturates at `BEATS`.
- `o_err` sets when `last` is seen at a count other than `BEATS-1`, or when the count reaches `BEATS` without `last`. In either case the FSM still follows `last`.
- `o_err` clears only on reset.

## Timing

- Arbitration latency:
  - A request raised in `R_IDLE` or `W_IDLE` at edge N appears on `m` from cycle N+1.
  - The arbiter adds 1 cycle per burst.
  - No combinational path runs from `s*.valid` to `m.*valid` while idle.
- Data-phase forwarding (`r`, `w`, `b`, ready/valid) is combinational.
  - No added latency per beat.
  - Throughput is 1 beat per cycle.
- The earliest re-grant is the cycle after the read burst's final beat, or after the write `b` handshake.
- Reset values: both FSMs idle; `o_rd_owner = 00`; `o_wr_owner = 00`; `o_err = 0`; all `m` valids 0; all `s*` readys and valids 0; `m.rready = 0`; `m.bready = 0`.
- Reset asserted mid-burst:
  - FSMs return to idle on the next edge.
  - The in-flight burst is abandoned. The bench resets the memory model alongside.
  - Round-robin priority returns to port 0.
- Requester rule: a requester must hold `ar.valid` / `aw.valid` until its handshake, per AXI.

## Configuration

- **`AXI_ARB_RR_EN` defined:** round-robin arbitration.
  - A 1-bit last-winner register per channel, reset to port 1, so port 0 wins first after reset.
  - On a simultaneous request, the port that did not win last gets the grant.
- **`AXI_ARB_RR_EN` undefined:** fixed priority.
  - Port 1 (data cache) always wins a simultaneous request.
  - No last-winner register.

## Test plan

- **Single read:** reset, then `s0.ar.addr = 0x0000_1000`; memory returns `BEATS` beats `0xA0 + 4*i`.
  - `m.ar.addr = 0x1000` one cycle after the request.
  - `s0` receives all beats in order, `last` on beat `BEATS-1`.
  - `o_rd_owner` goes `01` then `00`.
  - `o_err = 0`.
- **Read contention:** `s0` and `s1` assert `ar` on the same edge, addresses `0x100` / `0x200`.
  - RR build: `0x100` burst completes before `0x200` is issued. A second simultaneous pair is then served `s1` first.
  - Fixed build: `0x200` first on both pairs.
- **Concurrent read/write:** `s1` write-back to `0x3000` with data `0xDEAD_0000 + i`, while `s0` reads `0x4000`.
  - Both bursts proceed in overlapping cycles.
  - `m.w` data matches beat-exact.
  - `b` is routed only to `s1`.
  - `o_wr_owner = 10` and `o_rd_owner = 01` simultaneously.
- **Grant lock:** `s0` raises `ar` mid-way through an `s1` read burst.
  - `s0.arready` stays 0 until the cycle after `s1` receives `r.last`.
  - `s0` is then granted.
- **Protocol error:** memory asserts `r.last` on beat 1 with `BEATS = 4`.
  - `o_err = 1` and remains set.
  - Read FSM returns to idle.
  - The next burst is arbitrated normally.
- **Reset mid-burst:** assert `i_reset` during beat 2 of a write.
  - Next edge: owners `00`, all valids and readys 0, `o_err = 0`.
  - A fresh read after release completes correctly.
